sevenseg_scroll_ctrl: RTL

//  Message-scroll controller for the 8-digit 7-segment display driver. Buffers 5-bit display

---
 rtl/sevenseg_scroll_ctrl_if.sv | 24 ++
 rtl/sevenseg_scroll_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/sevenseg_scroll_ctrl_if.sv
// Character stream into the scroll controller: one {eom, dp, code} entry per valid & ready.
interface sevenseg_scroll_ctrl_if;
    logic [4:0] char_in;
    logic       char_dp;
    logic       char_eom;
    logic       char_valid;
    logic       char_ready;

    modport master (
        output char_in,
        output char_dp,
        output char_eom,
        output char_valid,
        input  char_ready
    );

    modport slave (
        input  char_in,
        input  char_dp,
        input  char_eom,
        input  char_valid,
        output char_ready
    );
endinterface

// File: rtl/sevenseg_scroll_ctrl.sv
// Message-scroll controller: buffers display codes in a FIFO and scrolls them across d0..d7.
// Optional SEVENSEG_SCROLL_BLINK_EN: the held message blinks against all-blank on each tick.
module sevenseg_scroll_ctrl #(
    parameter int unsigned CLK_FREQUENCY_HZ   = 100000000,
    parameter int unsigned SHIFT_RATE_HZ      = 4,
    parameter int unsigned FIFO_DEPTH         = 16,
    parameter int unsigned HOLD_SHIFTS        = 8,
    parameter int unsigned SIMULATE           = 0,
    parameter int unsigned SIMULATE_SHIFT_CNT = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    sevenseg_scroll_ctrl_if.slave         char_bus,
    input  logic                          scroll_en,
    input  logic                          clear,
    output logic [4:0]                    d0,
    output logic [4:0]                    d1,
    output logic [4:0]                    d2,
    output logic [4:0]                    d3,
    output logic [4:0]                    d4,
    output logic [4:0]                    d5,
    output logic [4:0]                    d6,
    output logic [4:0]                    d7,
    output logic [7:0]                    dp,
    output logic                          busy,
    output logic                          msg_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned TOP    = (SIMULATE != 0) ? SIMULATE_SHIFT_CNT
                                                     : CLK_FREQUENCY_HZ / SHIFT_RATE_HZ - 1;
    localparam int unsigned CNT_W  = (TOP > 0) ? $clog2(TOP + 1) : 1;
    localparam int unsigned AW     = $clog2(FIFO_DEPTH);
    localparam int unsigned CW     = AW + 1;
    localparam int unsigned HOLD_W = (HOLD_SHIFTS > 0) ? $clog2(HOLD_SHIFTS + 1) : 1;

    localparam logic [CNT_W-1:0]  TOP_C   = CNT_W'(TOP);
    localparam logic [CW-1:0]     DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [HOLD_W-1:0] HOLD_C  = HOLD_W'(HOLD_SHIFTS);
    localparam logic [4:0]        BLANK   = 5'd23;

    typedef enum logic [1:0] {StIdle, StScroll, StHold, StDrain} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [2:0]        drain_q, drain_d;
    logic [7:0][4:0]   digits_q, digits_d;
    logic [7:0]        dps_q, dps_d;
    logic              done_q, done_d;

    logic [6:0]        mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic [6:0]        head;
    logic              push, pop, tick;
    logic              shift_in;
    logic [4:0]        shift_code;
    logic              shift_dp;
    logic [7:0][4:0]   disp_digits;
    logic [7:0]        disp_dp;

    // ---------------- FIFO ----------------
    assign char_bus.char_ready = ~clear & (count_q < DEPTH_C);
    assign push = char_bus.char_valid & char_bus.char_ready;
    assign head = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {char_bus.char_eom, char_bus.char_dp, char_bus.char_in};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push && !pop)      count_q <= count_q + CW'(1);
            else if (pop && !push) count_q <= count_q - CW'(1);
        end
    end

    // ---------------- Scroll FSM ----------------
    assign tick = (state_q != StIdle) & scroll_en & (cnt_q == TOP_C);

`ifdef SEVENSEG_SCROLL_BLINK_EN
    logic blank_q, blank_d;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hold_d     = hold_q;
        drain_d    = drain_q;
        digits_d   = digits_q;
        dps_d      = dps_q;
        done_d     = 1'b0;
        pop        = 1'b0;
        shift_in   = 1'b0;
        shift_code = BLANK;
        shift_dp   = 1'b0;
`ifdef SEVENSEG_SCROLL_BLINK_EN
        blank_d    = blank_q;
`endif

        if (state_q != StIdle && scroll_en) begin
            cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (count_q != '0 && scroll_en) begin
                    state_d = StScroll;
                    cnt_d   = '0;
                end
            end
            StScroll: begin
                if (tick) begin
                    shift_in = 1'b1;
                    // Empty FIFO at the tick: the blank default is shifted in (underrun).
                    if (count_q != '0) begin
                        pop        = 1'b1;
                        shift_code = head[4:0];
                        shift_dp   = head[5];
                        if (head[6]) begin
                            state_d = StHold;
                            hold_d  = HOLD_C;
                        end
                    end
                end
            end
            StHold: begin
                if (tick) begin
                    if (hold_q <= HOLD_W'(1)) begin
                        hold_d  = '0;
                        drain_d = '0;
                        state_d = StDrain;
`ifdef SEVENSEG_SCROLL_BLINK_EN
                        blank_d = 1'b0;
`endif
                    end else begin
                        hold_d  = hold_q - HOLD_W'(1);
`ifdef SEVENSEG_SCROLL_BLINK_EN
                        blank_d = ~blank_q;
`endif
                    end
                end
            end
            StDrain: begin
                if (tick) begin
                    shift_in = 1'b1;
                    if (drain_q == 3'd7) begin
                        drain_d = '0;
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else begin
                        drain_d = drain_q + 3'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (shift_in) begin
            digits_d = {digits_q[6:0], shift_code};
            dps_d    = {dps_q[6:0], shift_dp};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            hold_q   <= '0;
            drain_q  <= '0;
            digits_q <= {8{BLANK}};
            dps_q    <= '0;
            done_q   <= 1'b0;
        end else if (clear) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            hold_q   <= '0;
            drain_q  <= '0;
            digits_q <= {8{BLANK}};
            dps_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hold_q   <= hold_d;
            drain_q  <= drain_d;
            digits_q <= digits_d;
            dps_q    <= dps_d;
            done_q   <= done_d;
        end
    end

`ifdef SEVENSEG_SCROLL_BLINK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)      blank_q <= 1'b0;
        else if (clear) blank_q <= 1'b0;
        else            blank_q <= blank_d;
    end

    // Held contents stay in digits_q; blinking only masks the outputs.
    assign disp_digits = blank_q ? {8{BLANK}} : digits_q;
    assign disp_dp     = blank_q ? 8'h00 : dps_q;
`else
    assign disp_digits = digits_q;
    assign disp_dp     = dps_q;
`endif

    assign d0         = disp_digits[0];
    assign d1         = disp_digits[1];
    assign d2         = disp_digits[2];
    assign d3         = disp_digits[3];
    assign d4         = disp_digits[4];
    assign d5         = disp_digits[5];
    assign d6         = disp_digits[6];
    assign d7         = disp_digits[7];
    assign dp         = disp_dp;
    assign busy       = (state_q != StIdle);
    assign msg_done   = done_q;
    assign fifo_count = count_q;

endmodule
